// File: rtl/seg_display_decoder.sv
// seg_display_decoder: receiver for a time-multiplexed 4-digit seven-segment bus.
// Waits for each anode strobe to settle, decodes the glyph back to a digit code
// and publishes complete 4-digit frames with error and change flags.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no valid strobe on the bus, counter held at 0
// ST_SETTLE   | valid strobe seen, counting consecutive stable cycles
// ST_CAPTURED | current strobe already captured, waiting for the bus to change
module seg_display_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  segment,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dp_mask,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        value_changed
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } state_t;

    logic [6:0]  seg_norm;
    logic [3:0]  an_norm;
    logic        dp_norm;

    logic [6:0]  seg_q, seg_prev_q;
    logic [3:0]  an_q, an_prev_q;
    logic        dp_q, dp_prev_q;

    state_t      state_q;
    logic [7:0]  cnt_q;

    logic [15:0] shadow_code_q;
    logic [3:0]  shadow_dp_q;
    logic [3:0]  shadow_err_q;
    logic [3:0]  mask_q, mask_d;

    logic [15:0] digits_q;
    logic [3:0]  dp_mask_q;
    logic [3:0]  digit_err_q;
    logic        frame_valid_q;
    logic        value_changed_q;

    logic        strobe_valid;
    logic        bus_changed;
    logic        settle_one;
    logic        capture;
    logic        publish;
    logic [1:0]  idx;
    logic [3:0]  code_dec;
    logic        err_dec;

    assign seg_norm = SEG_ACTIVE_LOW ? ~segment : segment;
    assign dp_norm  = SEG_ACTIVE_LOW ? ~dp      : dp;
    assign an_norm  = AN_ACTIVE_LOW  ? ~an      : an;

    // Single input register stage plus a one-cycle history for stability checks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q      <= '0;
            an_q       <= '0;
            dp_q       <= 1'b0;
            seg_prev_q <= '0;
            an_prev_q  <= '0;
            dp_prev_q  <= 1'b0;
        end else begin
            seg_q      <= seg_norm;
            an_q       <= an_norm;
            dp_q       <= dp_norm;
            seg_prev_q <= seg_q;
            an_prev_q  <= an_q;
            dp_prev_q  <= dp_q;
        end
    end

    // Strobe qualification, anode index and change detection
    always_comb begin
        strobe_valid = (an_q != 4'd0) && ((an_q & (an_q - 4'd1)) == 4'd0);
        bus_changed  = (an_q != an_prev_q) || (seg_q != seg_prev_q) || (dp_q != dp_prev_q);
        settle_one   = (SETTLE_C == 8'd1);
        idx          = 2'd0;
        case (an_q)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Glyph to digit code; blank is legal and decodes to F
    always_comb begin
        code_dec = 4'hE;
        err_dec  = 1'b1;
        case (seg_q)
            7'h3F: begin code_dec = 4'h0; err_dec = 1'b0; end
            7'h06: begin code_dec = 4'h1; err_dec = 1'b0; end
            7'h5B: begin code_dec = 4'h2; err_dec = 1'b0; end
            7'h4F: begin code_dec = 4'h3; err_dec = 1'b0; end
            7'h66: begin code_dec = 4'h4; err_dec = 1'b0; end
            7'h6D: begin code_dec = 4'h5; err_dec = 1'b0; end
            7'h7D: begin code_dec = 4'h6; err_dec = 1'b0; end
            7'h07: begin code_dec = 4'h7; err_dec = 1'b0; end
            7'h7F: begin code_dec = 4'h8; err_dec = 1'b0; end
            7'h6F: begin code_dec = 4'h9; err_dec = 1'b0; end
            7'h00: begin code_dec = 4'hF; err_dec = 1'b0; end
            default: begin code_dec = 4'hE; err_dec = 1'b1; end
        endcase
    end

    // Capture fires on the cycle the settle count reaches SETTLE_CYCLES; a fresh
    // strobe counts as 1, so a threshold of 1 captures immediately
    always_comb begin
        capture = 1'b0;
        case (state_q)
            ST_IDLE:     capture = strobe_valid && settle_one;
            ST_SETTLE:   capture = strobe_valid &&
                                   (bus_changed ? settle_one : ((cnt_q + 8'd1) == SETTLE_C));
            ST_CAPTURED: capture = strobe_valid && bus_changed && settle_one;
            default:     capture = 1'b0;
        endcase
        publish = (mask_q == 4'hF);
        mask_d  = (publish ? 4'h0 : mask_q) | (capture ? an_q : 4'h0);
    end

    // Strobe settle FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_q <= ST_CAPTURED;
                        cnt_q   <= '0;
                    end else if (strobe_valid) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= 8'd1;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!strobe_valid) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (capture) begin
                        state_q <= ST_CAPTURED;
                        cnt_q   <= '0;
                    end else if (bus_changed) begin
                        cnt_q   <= 8'd1;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                    end
                end
                ST_CAPTURED: begin
                    if (bus_changed) begin
                        if (!strobe_valid) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else if (capture) begin
                            state_q <= ST_CAPTURED;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Shadow frame assembly; slot chosen by anode index, re-capture overwrites
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_code_q <= '0;
            shadow_dp_q   <= '0;
            shadow_err_q  <= '0;
            mask_q        <= '0;
        end else begin
            mask_q <= mask_d;
            if (capture) begin
                shadow_code_q[{idx, 2'b00} +: 4] <= code_dec;
                shadow_dp_q[idx]                 <= dp_q;
                shadow_err_q[idx]                <= err_dec;
            end
        end
    end

    // Publish the completed frame one cycle after the mask fills
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q        <= 16'hFFFF;
            dp_mask_q       <= '0;
            digit_err_q     <= '0;
            frame_valid_q   <= 1'b0;
            value_changed_q <= 1'b0;
        end else begin
            frame_valid_q   <= publish;
            value_changed_q <= 1'b0;
            if (publish) begin
                digits_q        <= shadow_code_q;
                dp_mask_q       <= shadow_dp_q;
                digit_err_q     <= shadow_err_q;
                value_changed_q <= ({shadow_code_q, shadow_dp_q} != {digits_q, dp_mask_q});
            end
        end
    end

    assign digits        = digits_q;
    assign dp_mask       = dp_mask_q;
    assign digit_err     = digit_err_q;
    assign frame_valid   = frame_valid_q;
    assign value_changed = value_changed_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Bench for seg_display_decoder: directed scans plus random strobe sequences,
// checked against a strobe-level model of frame assembly.
module tb_seg_display_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  segment;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        value_changed;

    seg_display_decoder #(
        .SETTLE_CYCLES (S),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .segment      (segment),
        .an           (an),
        .dp           (dp),
        .digits       (digits),
        .dp_mask      (dp_mask),
        .digit_err    (digit_err),
        .frame_valid  (frame_valid),
        .value_changed(value_changed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [3:0]  dpm;
        logic [3:0]  err;
        logic        vc;
    } frame_t;

    frame_t obs_q[$];
    frame_t exp_q[$];
    frame_t mon_f;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reference model state: one partial frame plus the last published frame
    logic [3:0]  m_code [4];
    logic        m_dp   [4];
    logic        m_err  [4];
    logic [3:0]  m_mask;
    logic [15:0] m_prev_d;
    logic [3:0]  m_prev_dp;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            mon_f.cyc = cyc;
            mon_f.d   = digits;
            mon_f.dpm = dp_mask;
            mon_f.err = digit_err;
            mon_f.vc  = value_changed;
            obs_q.push_back(mon_f);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_code[k] = 4'h0;
            m_dp[k]   = 1'b0;
            m_err[k]  = 1'b0;
        end
        m_mask    = 4'h0;
        m_prev_d  = 16'hFFFF;
        m_prev_dp = 4'h0;
    endtask

    task automatic model_decode(input logic [6:0] p, output logic [3:0] c, output logic e);
        c = 4'hE;
        e = 1'b1;
        if (p == 7'h00) begin
            c = 4'hF;
            e = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            if (glyph[k] == p) begin
                c = 4'(k);
                e = 1'b0;
            end
        end
    endtask

    task automatic model_capture(input int slot, input logic [6:0] p, input logic d, input int cap_cyc);
        logic [3:0] c;
        logic       e;
        frame_t     f;
        model_decode(p, c, e);
        m_code[slot] = c;
        m_dp[slot]   = d;
        m_err[slot]  = e;
        m_mask[slot] = 1'b1;
        if (m_mask == 4'hF) begin
            f.cyc = cap_cyc + 1;
            f.d   = 16'h0;
            f.dpm = 4'h0;
            f.err = 4'h0;
            for (int k = 0; k < 4; k++) begin
                f.d      = f.d | (16'(m_code[k]) << (4 * k));
                f.dpm[k] = m_dp[k];
                f.err[k] = m_err[k];
            end
            f.vc = ({f.d, f.dpm} != {m_prev_d, m_prev_dp});
            exp_q.push_back(f);
            m_prev_d  = f.d;
            m_prev_dp = f.dpm;
            m_mask    = 4'h0;
        end
    endtask

    // one strobe of normalised values held for 'hold' cycles; called at a negedge
    task automatic step(input logic [3:0] an_n, input logic [6:0] seg_n, input logic dp_n, input int hold);
        int first;
        int slot;
        an      = ~an_n;
        segment = ~seg_n;
        dp      = ~dp_n;
        first   = cyc + 1;
        repeat (hold) @(negedge clk);
        if ($countones(an_n) == 1 && hold >= S) begin
            slot = 0;
            for (int k = 0; k < 4; k++) if (an_n[k]) slot = k;
            model_capture(slot, seg_n, dp_n, first + S);
        end
    endtask

    task automatic idle(input int n);
        step(4'h0, 7'h00, 1'b0, n);
    endtask

    task automatic scan4(input logic [15:0] code, input logic [3:0] dpm, input int hold);
        logic [3:0] c;
        for (int k = 3; k >= 0; k--) begin
            c = code[4*k +: 4];
            step(4'b0001 << k, glyph[c], dpm[k], hold);
        end
    endtask

    task automatic compare_frames(input string tag);
        frame_t o;
        frame_t e;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_cycle"},   o.cyc, e.cyc);
            chk({tag, "_digits"},  o.d,   e.d);
            chk({tag, "_dp_mask"}, o.dpm, e.dpm);
            chk({tag, "_err"},     o.err, e.err);
            chk({tag, "_changed"}, o.vc,  e.vc);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        an      = 4'hF;
        segment = 7'h7F;
        dp      = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;
    logic [3:0] p_an;
    logic [6:0] p_seg;
    logic       p_dp;
    int         r_hold;
    int         r_sel;

    initial begin
        reset   = 1'b0;
        an      = 4'hF;
        segment = 7'h7F;
        dp      = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_digits",  digits,        16'hFFFF);
        chk("rst_dp_mask", dp_mask,       4'h0);
        chk("rst_err",     digit_err,     4'h0);
        chk("rst_valid",   frame_valid,   1'b0);
        chk("rst_changed", value_changed, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // idle bus: nothing decoded, no frames
        idle(100);
        compare_frames("idle");
        chk("idle_digits", digits, 16'hFFFF);

        // "12.34" scanned twice
        scan4(16'h1234, 4'b0100, 8);
        scan4(16'h1234, 4'b0100, 8);
        idle(4);
        compare_frames("scan1234");
        chk("hold_digits", digits, m_prev_d);

        // digit1 strobe one cycle short of the settle threshold
        step(4'b1000, glyph[5], 1'b0, 8);
        step(4'b0100, glyph[6], 1'b0, 8);
        step(4'b0010, glyph[7], 1'b1, S - 1);
        step(4'b0001, glyph[8], 1'b0, 8);
        idle(6);
        compare_frames("short");
        step(4'b0010, glyph[7], 1'b1, S);
        idle(4);
        compare_frames("short_fix");

        // illegal pattern on digit0
        step(4'b1000, glyph[9], 1'b0, 8);
        step(4'b0100, glyph[8], 1'b0, 8);
        step(4'b0010, glyph[7], 1'b0, 8);
        step(4'b0001, 7'h49,    1'b0, 8);
        idle(4);
        compare_frames("illegal");

        // two-anode glitches between digits
        step(4'b1000, glyph[1], 1'b0, 8);
        step(4'b0011, glyph[3], 1'b0, 3);
        step(4'b0100, glyph[2], 1'b1, 8);
        step(4'b0011, glyph[3], 1'b0, 3);
        step(4'b0010, glyph[3], 1'b0, 8);
        step(4'b0011, glyph[8], 1'b1, 3);
        step(4'b0001, glyph[4], 1'b0, 8);
        idle(4);
        compare_frames("glitch");

        // reset after three digits captured discards the partial frame
        step(4'b1000, glyph[5], 1'b0, 8);
        step(4'b0100, glyph[5], 1'b0, 8);
        step(4'b0010, glyph[5], 1'b0, 8);
        idle(6);
        do_reset();
        chk("rst2_digits", digits, 16'hFFFF);
        scan4(16'h0000, 4'b0000, 8);
        idle(4);
        compare_frames("reset_mid");

        // random strobes, including short, glitched and illegal ones
        p_an  = 4'h0;
        p_seg = 7'h00;
        p_dp  = 1'b0;
        for (int i = 0; i < 120; i++) begin
            r_sel = $urandom_range(0, 9);
            if (r_sel < 7)       r_an = 4'b0001 << $urandom_range(0, 3);
            else if (r_sel == 7) r_an = 4'h0;
            else                 r_an = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) r_seg = 7'($urandom_range(0, 127));
            else                           r_seg = glyph[$urandom_range(0, 9)];
            r_dp   = 1'($urandom_range(0, 1));
            r_hold = $urandom_range(1, 2 * S + 1);
            if ({r_an, r_seg, r_dp} == {p_an, p_seg, p_dp}) r_dp = ~r_dp;
            step(r_an, r_seg, r_dp, r_hold);
            p_an  = r_an;
            p_seg = r_seg;
            p_dp  = r_dp;
        end
        idle(6);
        compare_frames("random");
        chk("final_digits",  digits,  m_prev_d);
        chk("final_dp_mask", dp_mask, m_prev_dp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
